// File: rtl/queue_arbiter.sv
// Two-requester round-robin arbiter that sequences push/pop/write/peek commands into
// the queue block, tracks occupancy and returns pop/peek data.
module queue_arbiter #(
  parameter int         DEPTH    = 8,
  parameter logic [1:0] OP_WRITE = 2'b00,
  parameter logic [1:0] OP_IDLE  = 2'b01,
  parameter logic [1:0] OP_PUSH  = 2'b10,
  parameter logic [1:0] OP_POP   = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0][1:0] req_op,
  input  logic [1:0][7:0] req_data,
  input  logic [1:0][2:0] req_pos,
  output logic [1:0]      req_ready,
  output logic            resp_valid,
  output logic            resp_id,
  output logic [15:0]     resp_data,
  output logic [1:0]      q_opcode,
  output logic [7:0]      q_back,
  output logic [2:0]      q_pos_back,
  input  logic [15:0]     q_top_conc,
  output logic [3:0]      count,
  output logic            full,
  output logic            empty
);

  // state  | meaning
  // IDLE   | arbitrate; winner's command is registered toward the queue
  // ISSUE  | queue executes the registered command at the closing edge
  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  localparam logic [1:0] REQ_WRITE = 2'b00;
  localparam logic [1:0] REQ_PUSH  = 2'b01;
  localparam logic [1:0] REQ_POP   = 2'b10;
  localparam logic [1:0] REQ_PEEK  = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] elig;
  logic       winner;
  logic       accept;
  logic       rr;
  logic       cmd_id;
  logic [1:0] cmd_op;

  function automatic logic [1:0] to_qop(input logic [1:0] op);
    case (op)
      REQ_WRITE: return OP_WRITE;
      REQ_PUSH:  return OP_PUSH;
      REQ_POP:   return OP_POP;
      default:   return OP_IDLE;
    endcase
  endfunction

  assign full  = (count == 4'(DEPTH));
  assign empty = (count == 4'd0);

  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      case (req_op[i])
        REQ_PUSH:         elig[i] = req_valid[i] && !full;
        REQ_POP, REQ_PEEK: elig[i] = req_valid[i] && !empty;
        default:          elig[i] = req_valid[i];
      endcase
    end
    winner = (elig == 2'b11) ? rr : elig[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|elig) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    accept    = (state == S_IDLE) && (|elig);
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_opcode   <= OP_IDLE;
      q_back     <= '0;
      q_pos_back <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      rr         <= 1'b0;
      cmd_id     <= 1'b0;
      cmd_op     <= REQ_PEEK;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        q_opcode   <= to_qop(req_op[winner]);
        q_back     <= req_data[winner];
        q_pos_back <= req_pos[winner];
        cmd_op     <= req_op[winner];
        cmd_id     <= winner;
        rr         <= ~winner;
      end else if (state == S_ISSUE) begin
        q_opcode <= OP_IDLE;
        if (cmd_op == REQ_PUSH && count != 4'(DEPTH)) count <= count + 4'd1;
        if (cmd_op == REQ_POP && count != 4'd0)       count <= count - 4'd1;
        // response carries the front as seen before the pop takes effect
        if (cmd_op == REQ_POP || cmd_op == REQ_PEEK) begin
          resp_valid <= 1'b1;
          resp_id    <= cmd_id;
          resp_data  <= q_top_conc;
        end
      end
    end
  end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter with a small behavioural queue on the q_* side.
module tb_queue_arbiter;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0][1:0] req_op    = '0;
  logic [1:0][7:0] req_data  = '0;
  logic [1:0][2:0] req_pos   = '0;
  logic [1:0]      req_ready;
  logic            resp_valid;
  logic            resp_id;
  logic [15:0]     resp_data;
  logic [1:0]      q_opcode;
  logic [7:0]      q_back;
  logic [2:0]      q_pos_back;
  logic [15:0]     q_top_conc;
  logic [3:0]      count;
  logic            full;
  logic            empty;

  int n_cmp = 0;
  int n_err = 0;

  queue_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_pos(req_pos),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .q_opcode(q_opcode), .q_back(q_back), .q_pos_back(q_pos_back), .q_top_conc(q_top_conc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // behavioural queue: front at qm[0], top_conc shows the two front entries
  logic [7:0] qm [8];
  int         qn;
  assign q_top_conc = {qm[1], qm[0]};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 8; j++) qm[j] <= 8'd0;
      qn <= 0;
    end else begin
      case (q_opcode)
        2'b10: begin qm[qn[2:0]] <= q_back; qn <= qn + 1; end
        2'b11: begin
          for (int j = 0; j < 7; j++) qm[j] <= qm[j+1];
          qm[7] <= 8'd0;
          qn <= qn - 1;
        end
        2'b00: qm[q_pos_back] <= q_back;
        default: ;
      endcase
    end
  end

  localparam logic [1:0] C_WRITE = 2'b00, C_PUSH = 2'b01, C_POP = 2'b10, C_PEEK = 2'b11;

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present a command and wait (bounded) for its accept; returns at accept edge + 1.
  task automatic do_cmd(input int id, input logic [1:0] op, input logic [7:0] d,
                        input logic [2:0] p, output bit ok);
    ok = 1'b0;
    req_op[id] = op; req_data[id] = d; req_pos[id] = p; req_valid[id] = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (req_ready[id] === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (q_opcode !== 2'b01) begin n_err++; $display("FAIL reset_opcode got=%b exp=01", q_opcode); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b exp=10", empty, full); end
    n_cmp++; if (resp_valid !== 1'b0 || resp_data !== 16'h0) begin n_err++; $display("FAIL reset_resp got=%b/%h exp=0/0000", resp_valid, resp_data); end
    rst = 1'b0;
    do_cmd(0, C_PUSH, 8'd9, 3'd0, ok);
    n_cmp++; if (!ok || q_opcode !== 2'b10) begin n_err++; $display("FAIL rst_issue_push got=%0d/%b exp=1/10", ok, q_opcode); end
    rst = 1'b1; #1;
    n_cmp++; if (q_opcode !== 2'b01) begin n_err++; $display("FAIL rst_async_opcode got=%b exp=01", q_opcode); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_abort got=%0d/%b exp=0/0", count, resp_valid); end
  endtask

  task automatic test_fill();
    bit ok;
    bit seen;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      do_cmd(0, C_PUSH, 8'(k), 3'd0, ok);
      n_cmp++; if (!ok || q_opcode !== 2'b10 || q_back !== 8'(k)) begin n_err++; $display("FAIL fill_issue%0d got=%0d/%b/%0d exp=1/10/%0d", k, ok, q_opcode, q_back, k); end
      @(posedge clk); #1;
      n_cmp++; if (count !== 4'(k) || q_opcode !== 2'b01) begin n_err++; $display("FAIL fill_count%0d got=%0d/%b exp=%0d/01", k, count, q_opcode, k); end
    end
    n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_err++; $display("FAIL fill_full got=%b%b exp=10", full, empty); end
    seen = 1'b0;
    req_op[0] = C_PUSH; req_data[0] = 8'd9; req_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1; if (req_ready[0] !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    n_cmp++; if (seen || count !== 4'd8) begin n_err++; $display("FAIL fill_overflow_stall got=%0d/%0d exp=0/8", seen, count); end
  endtask

  task automatic test_pop_order();
    bit ok;
    do_reset();
    do_cmd(0, C_PUSH, 8'd1, 3'd0, ok); @(posedge clk); #1;
    do_cmd(0, C_PUSH, 8'd2, 3'd0, ok); @(posedge clk); #1;
    do_cmd(0, C_POP, 8'd0, 3'd0, ok);
    n_cmp++; if (!ok || q_opcode !== 2'b11 || resp_valid !== 1'b0) begin n_err++; $display("FAIL pop_issue got=%0d/%b/%b exp=1/11/0", ok, q_opcode, resp_valid); end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'h0201 || resp_id !== 1'b0) begin n_err++; $display("FAIL pop_resp got=%b/%h/%b exp=1/0201/0", resp_valid, resp_data, resp_id); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL pop_count got=%0d exp=1", count); end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL pop_strobe_len got=%b exp=0", resp_valid); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int n;
    logic [3:0] grants;
    do_reset();
    n = 0; grants = '0;
    req_op[0] = C_PUSH; req_op[1] = C_PUSH; req_data[0] = 8'h20; req_data[1] = 8'h30;
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        if (n < 4) grants[n] = req_ready[1];
        n++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    n_cmp++; if (n !== 4 || grants !== 4'b1010) begin n_err++; $display("FAIL rr_alternate got=%0d/%b exp=4/1010", n, grants); end
    do_cmd(0, C_PUSH, 8'h21, 3'd0, ok);
    req_valid = 2'b11;
    @(posedge clk); #1;
    n_cmp++; if (!ok || req_ready !== 2'b10) begin n_err++; $display("FAIL rr_pointer got=%0d/%b exp=1/10", ok, req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL rr_count got=%0d exp=6", count); end
  endtask

  task automatic test_full_contention();
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      do_cmd(0, C_PUSH, 8'(10 + k), 3'd0, ok); @(posedge clk); #1;
    end
    req_op[0] = C_PUSH; req_data[0] = 8'd99; req_op[1] = C_POP;
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b10 || count !== 4'd8) begin n_err++; $display("FAIL fc_pop_first got=%b/%0d exp=10/8", req_ready, count); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n_cmp++; if (q_opcode !== 2'b11) begin n_err++; $display("FAIL fc_pop_opcode got=%b exp=11", q_opcode); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd7 || resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 16'h0B0A) begin
      n_err++; $display("FAIL fc_pop_resp got=%0d/%b/%b/%h exp=7/1/1/0b0a", count, resp_valid, resp_id, resp_data); end
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL fc_push_b2b got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_cmp++; if (q_opcode !== 2'b10 || q_back !== 8'd99) begin n_err++; $display("FAIL fc_push_issue got=%b/%0d exp=10/99", q_opcode, q_back); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL fc_refull got=%0d/%b exp=8/1", count, full); end
  endtask

  task automatic test_write_peek();
    bit ok;
    bit seen;
    do_reset();
    seen = 1'b0;
    req_op[1] = C_PEEK; req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1; if (req_ready !== 2'b00) seen = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    n_cmp++; if (seen || resp_valid !== 1'b0) begin n_err++; $display("FAIL peek_empty_stall got=%0d/%b exp=0/0", seen, resp_valid); end
    do_cmd(0, C_PUSH, 8'd5, 3'd0, ok); @(posedge clk); #1;
    do_cmd(0, C_WRITE, 8'd200, 3'd3, ok);
    n_cmp++; if (!ok || q_opcode !== 2'b00 || q_back !== 8'd200 || q_pos_back !== 3'd3) begin
      n_err++; $display("FAIL write_issue got=%0d/%b/%0d/%0d exp=1/00/200/3", ok, q_opcode, q_back, q_pos_back); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd1 || resp_valid !== 1'b0 || q_back !== 8'd200) begin n_err++; $display("FAIL write_after got=%0d/%b/%0d exp=1/0/200", count, resp_valid, q_back); end
    do_cmd(1, C_PEEK, 8'd0, 3'd0, ok);
    n_cmp++; if (!ok || q_opcode !== 2'b01) begin n_err++; $display("FAIL peek_issue got=%0d/%b exp=1/01", ok, q_opcode); end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 16'h0005 || count !== 4'd1) begin
      n_err++; $display("FAIL peek_resp got=%b/%b/%h/%0d exp=1/1/0005/1", resp_valid, resp_id, resp_data, count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_order();
    test_round_robin();
    test_full_contention();
    test_write_peek();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
